// File: rtl/int_to_half_norm.sv
// Integer-to-binary16 converter: a three-stage elastic pipeline (sign/magnitude,
// normalise, round/pack) with independent valid bits per stage.

module lzd16 (
   input  logic [15:0] value,
   output logic [3:0]  count,
   output logic        zero
);

   logic [3:0] nib_nz;
   logic [1:0] nib_cnt [4];

   // Per-nibble leading-zero count, then pick the highest non-empty nibble.
   always_comb begin
      for (int n = 0; n < 4; n++) begin
         nib_nz[n] = |value[n*4 +: 4];
         if (value[n*4+3])
            nib_cnt[n] = 2'd0;
         else if (value[n*4+2])
            nib_cnt[n] = 2'd1;
         else if (value[n*4+1])
            nib_cnt[n] = 2'd2;
         else
            nib_cnt[n] = 2'd3;
      end
   end

   always_comb begin
      count = 4'd0;
      zero  = ~|nib_nz;
      if (nib_nz[3])
         count = {2'd0, nib_cnt[3]};
      else if (nib_nz[2])
         count = {2'd1, nib_cnt[2]};
      else if (nib_nz[1])
         count = {2'd2, nib_cnt[1]};
      else
         count = {2'd3, nib_cnt[0]};
   end

endmodule

module int_to_half_norm #(
   parameter bit SIGNED = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] in_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] out_data
);

   // Handshake: a word moves on a port only in a cycle where valid && ready;
   // a producer holds valid and data steady until that happens, and a stage
   // refills whenever it is empty or its current word leaves in the same cycle.

   logic        s1_valid;
   logic        s1_sign;
   logic [15:0] s1_mag;

   logic        s2_valid;
   logic        s2_sign;
   logic        s2_zero;
   logic [3:0]  s2_lzc;
   logic [15:0] s2_norm;

   logic        s3_valid;
   logic [15:0] s3_data;

   logic        s1_load;
   logic        s2_load;
   logic        s3_load;

   always_comb begin
      s3_load  = !s3_valid || out_ready;
      s2_load  = !s2_valid || s3_load;
      s1_load  = !s1_valid || s2_load;
      in_ready = s1_load;
   end

   // Stage 1 inputs: -32768 negates to 0x8000, which is still the right magnitude.
   logic        in_neg;
   logic [15:0] in_mag;

   always_comb begin
      in_neg = SIGNED && in_data[15];
      in_mag = in_neg ? (~in_data + 16'd1) : in_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_sign  <= 1'b0;
         s1_mag   <= 16'd0;
      end else if (s1_load) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_sign <= in_neg;
            s1_mag  <= in_mag;
         end
      end
   end

   logic [3:0]  lzd_count;
   logic        lzd_zero;
   logic [15:0] mag_shifted;

   lzd16 u_lzd (
      .value (s1_mag),
      .count (lzd_count),
      .zero  (lzd_zero)
   );

   always_comb begin
      mag_shifted = s1_mag << lzd_count;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_valid <= 1'b0;
         s2_sign  <= 1'b0;
         s2_zero  <= 1'b1;
         s2_lzc   <= 4'd0;
         s2_norm  <= 16'd0;
      end else if (s2_load) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_sign <= s1_sign;
            s2_zero <= lzd_zero;
            s2_lzc  <= lzd_count;
            s2_norm <= mag_shifted;
         end
      end
   end

   // The leading one sits at s2_norm[15] and is implicit in the result.
   // Adding the round bit to {exponent, mantissa} lets a mantissa carry
   // bump the exponent for free.
   logic [4:0]  exp_field;
   logic [9:0]  mant;
   logic        guard_bit;
   logic        sticky_bit;
   logic        round_up;
   logic [14:0] rounded;
   logic [15:0] packed_word;

   always_comb begin
      exp_field   = 5'd30 - {1'b0, s2_lzc};
      mant        = s2_norm[14:5];
      guard_bit   = s2_norm[4];
      sticky_bit  = |s2_norm[3:0];
      round_up    = guard_bit && (sticky_bit || mant[0]);
      rounded     = {exp_field, mant} + {14'd0, round_up};
      packed_word = s2_zero ? 16'h0000 : {s2_sign, rounded};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s3_valid <= 1'b0;
         s3_data  <= 16'h0000;
      end else if (s3_load) begin
         s3_valid <= s2_valid;
         if (s2_valid)
            s3_data <= packed_word;
      end
   end

   always_comb begin
      out_valid = s3_valid;
      out_data  = s3_data;
   end

endmodule

// File: tb/tb_int_to_half_norm.sv
// Bench for int_to_half_norm: a signed (index 1) and an unsigned (index 0)
// instance, table vectors, hand sequences and a random stream vs a reference.

module tb_int_to_half_norm;

   logic        clk;
   logic        rst;
   logic        in_v  [2];
   logic        in_r  [2];
   logic [15:0] in_d  [2];
   logic        out_v [2];
   logic        out_r [2];
   logic [15:0] out_d [2];

   int total;
   int bad;

   logic [15:0] exp_q_s[$];
   logic [15:0] exp_q_u[$];
   int in_cnt_s, out_cnt_s, in_cnt_u, out_cnt_u;

   int_to_half_norm #(.SIGNED(1'b1)) dut_s (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_v[1]),
      .in_ready  (in_r[1]),
      .in_data   (in_d[1]),
      .out_valid (out_v[1]),
      .out_ready (out_r[1]),
      .out_data  (out_d[1])
   );

   int_to_half_norm #(.SIGNED(1'b0)) dut_u (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_v[0]),
      .in_ready  (in_r[0]),
      .in_data   (in_d[0]),
      .out_valid (out_v[0]),
      .out_ready (out_r[0]),
      .out_data  (out_d[0])
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   function automatic logic [15:0] ref_half(input logic [15:0] d, input bit is_signed);
      int  v, e, q, r, half, sh;
      bit  neg;
      neg = is_signed && d[15];
      v   = int'({16'd0, d});
      if (neg) v = 65536 - v;
      if (v == 0) return 16'h0000;
      e = 0;
      while ((1 << (e + 1)) <= v) e++;
      if (e <= 10) begin
         q = v << (10 - e);
      end else begin
         sh   = e - 10;
         q    = v >> sh;
         r    = v - (q << sh);
         half = 1 << (sh - 1);
         if (r > half || (r == half && (q % 2) == 1)) q++;
      end
      if (q == 2048) begin
         q = 1024;
         e++;
      end
      if (e + 15 >= 31) return neg ? 16'hFC00 : 16'h7C00;
      return {neg, 5'(e + 15), 10'(q - 1024)};
   endfunction

   // ---------------- checking ----------------
   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, want);
      end
   endtask

   function automatic int q_size(input bit sel);
      return sel ? exp_q_s.size() : exp_q_u.size();
   endfunction

   // Scoreboards sample mid-cycle, so they see the handshake that the next edge commits.
   always @(negedge clk) begin
      if (rst) begin
         exp_q_s.delete();
         in_cnt_s  = 0;
         out_cnt_s = 0;
      end else begin
         if (in_v[1] && in_r[1]) begin
            exp_q_s.push_back(ref_half(in_d[1], 1'b1));
            in_cnt_s++;
         end
         if (out_v[1] && out_r[1]) begin
            out_cnt_s++;
            if (exp_q_s.size() == 0)
               chk("stream_s_unexpected", out_d[1], 16'hxxxx);
            else
               chk("stream_s", out_d[1], exp_q_s.pop_front());
         end
      end
   end

   always @(negedge clk) begin
      if (rst) begin
         exp_q_u.delete();
         in_cnt_u  = 0;
         out_cnt_u = 0;
      end else begin
         if (in_v[0] && in_r[0]) begin
            exp_q_u.push_back(ref_half(in_d[0], 1'b0));
            in_cnt_u++;
         end
         if (out_v[0] && out_r[0]) begin
            out_cnt_u++;
            if (exp_q_u.size() == 0)
               chk("stream_u_unexpected", out_d[0], 16'hxxxx);
            else
               chk("stream_u", out_d[0], exp_q_u.pop_front());
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic send_one(input bit sel, input logic [15:0] din,
                           input logic [15:0] want, input string name);
      int lat;
      out_r[sel] = 1'b1;
      @(posedge clk); #1;
      in_v[sel] = 1'b1;
      in_d[sel] = din;
      @(negedge clk);
      chk({name, "_ready"}, {15'd0, in_r[sel]}, 16'd1);
      @(posedge clk); #1;
      in_v[sel] = 1'b0;
      lat = 1;
      while (!out_v[sel] && lat < 10) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({name, "_latency"}, 16'(lat), 16'd3);
      chk({name, "_data"}, out_d[sel], want);
   endtask

   task automatic drain(input bit sel, input string name);
      int g;
      g = 0;
      out_r[sel] = 1'b1;
      while (q_size(sel) != 0 && g < 200) begin
         @(posedge clk); #1;
         g++;
      end
      chk({name, "_drained"}, 16'(q_size(sel)), 16'd0);
      @(posedge clk); #1;
   endtask

   function automatic logic [15:0] rand_word();
      logic [15:0] w;
      w = 16'($urandom);
      if ($urandom_range(0, 3) == 0) w = w >> $urandom_range(0, 15);
      return w;
   endfunction

   task automatic rand_stream(input bit sel, input int n, input string name);
      int  sent, guard;
      bit  acc;
      sent = 0;
      guard = 0;
      acc = 1'b0;
      in_v[sel] = 1'b0;
      while (sent < n && guard < n * 20) begin
         @(posedge clk); #1;
         guard++;
         if (!in_v[sel] || acc) begin
            in_v[sel] = ($urandom_range(0, 9) < 7);
            in_d[sel] = rand_word();
         end
         out_r[sel] = ($urandom_range(0, 9) < 7);
         @(negedge clk);
         acc = in_v[sel] && in_r[sel];
         if (acc) sent++;
      end
      @(posedge clk); #1;
      in_v[sel] = 1'b0;
      chk({name, "_sent"}, 16'(sent), 16'(n));
      drain(sel, name);
   endtask

   // ---------------- test ----------------
   typedef struct {
      bit          sel;
      logic [15:0] din;
      logic [15:0] want;
   } vec_t;

   vec_t vecs [14];

   initial begin
      int          acc;
      logic [15:0] hold;

      vecs[0]  = '{1'b1, 16'h0001, 16'h3C00};
      vecs[1]  = '{1'b1, 16'h0000, 16'h0000};
      vecs[2]  = '{1'b1, 16'h8000, 16'hF800};
      vecs[3]  = '{1'b1, 16'hFFFF, 16'hBC00};
      vecs[4]  = '{1'b1, 16'd2049, 16'h6800};
      vecs[5]  = '{1'b1, 16'd2051, 16'h6802};
      vecs[6]  = '{1'b1, 16'd32767, 16'h7800};
      vecs[7]  = '{1'b1, 16'h0400, 16'h6400};
      vecs[8]  = '{1'b1, 16'hFFFE, 16'hC000};
      vecs[9]  = '{1'b1, 16'h0004, 16'h4400};
      vecs[10] = '{1'b0, 16'hFFFF, 16'h7C00};
      vecs[11] = '{1'b0, 16'h8000, 16'h7800};
      vecs[12] = '{1'b0, 16'h0001, 16'h3C00};
      vecs[13] = '{1'b0, 16'h0000, 16'h0000};

      total = 0;
      bad   = 0;
      rst   = 1'b1;
      for (int i = 0; i < 2; i++) begin
         in_v[i]  = 1'b0;
         in_d[i]  = 16'h0000;
         out_r[i] = 1'b1;
      end

      // Reset state
      #12;
      chk("reset_out_valid_s", {15'd0, out_v[1]}, 16'd0);
      chk("reset_out_data_s", out_d[1], 16'h0000);
      chk("reset_out_valid_u", {15'd0, out_v[0]}, 16'd0);
      @(posedge clk); #2;
      rst = 1'b0;
      #1;
      chk("reset_in_ready_s", {15'd0, in_r[1]}, 16'd1);
      chk("reset_in_ready_u", {15'd0, in_r[0]}, 16'd1);

      // Table vectors
      for (int i = 0; i < 14; i++)
         send_one(vecs[i].sel, vecs[i].din, vecs[i].want, $sformatf("vec%0d", i));
      @(posedge clk); #1;

      // Back-to-back words, one per cycle
      out_r[1] = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_v[1] = 1'b1;
         in_d[1] = vecs[i].din;
         @(posedge clk); #1;
      end
      in_v[1] = 1'b0;
      drain(1'b1, "burst");
      chk("burst_count", 16'(out_cnt_s - in_cnt_s), 16'd0);

      // Backpressure: 8 incrementing words with downstream stalled
      out_r[1] = 1'b0;
      in_v[1]  = 1'b1;
      in_d[1]  = 16'd1;
      acc = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (in_r[1]) acc++;
         @(posedge clk); #1;
         in_d[1] = 16'(acc + 1);
      end
      chk("bp_accepted", 16'(acc), 16'd3);
      @(negedge clk);
      chk("bp_in_ready_low", {15'd0, in_r[1]}, 16'd0);
      chk("bp_out_valid", {15'd0, out_v[1]}, 16'd1);
      hold = out_d[1];
      @(negedge clk);
      chk("bp_stable", out_d[1], hold);
      chk("bp_head", out_d[1], 16'h3C00);
      @(posedge clk); #1;
      out_r[1] = 1'b1;
      for (int g = 0; g < 40 && acc < 8; g++) begin
         @(negedge clk);
         if (in_r[1]) acc++;
         @(posedge clk); #1;
         if (acc >= 8) in_v[1] = 1'b0;
         else in_d[1] = 16'(acc + 1);
      end
      in_v[1] = 1'b0;
      chk("bp_all_accepted", 16'(acc), 16'd8);
      drain(1'b1, "bp");

      // Reset with three words in flight
      out_r[1] = 1'b0;
      in_v[1]  = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         in_d[1] = 16'(k);
         @(posedge clk); #1;
      end
      in_v[1] = 1'b0;
      chk("rst_inflight_valid", {15'd0, out_v[1]}, 16'd1);
      #3;
      rst = 1'b1;
      #1;
      chk("rst_async_valid", {15'd0, out_v[1]}, 16'd0);
      chk("rst_async_data", out_d[1], 16'h0000);
      @(posedge clk);
      @(posedge clk); #2;
      rst = 1'b0;
      #1;
      chk("rst_release_ready", {15'd0, in_r[1]}, 16'd1);
      out_r[1] = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         chk("rst_no_stale", {15'd0, out_v[1]}, 16'd0);
      end
      send_one(1'b1, 16'h0004, 16'h4400, "rst_new");
      @(posedge clk); #1;

      // Random streams against the reference model
      rand_stream(1'b1, 10000, "rand_s");
      chk("rand_s_count", 16'(out_cnt_s - in_cnt_s), 16'd0);
      rand_stream(1'b0, 2000, "rand_u");
      chk("rand_u_count", 16'(out_cnt_u - in_cnt_u), 16'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
